// File: rtl/uart_tx_engine_if.sv
// Host-side bundle of the UART transmit engine: enqueue port, flow control, serial line and FIFO status.
interface uart_tx_engine_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] Tx_Data;
  logic                 Write_En;
  logic                 CTS;
  logic                 Overflow_Clr;
  logic                 Tx;
  logic                 Tx_Busy;
  logic                 FIFO_Empty;
  logic                 FIFO_Full;
  logic                 FIFO_Overflow;
  logic [CW-1:0]        FIFO_Count;

  modport master (
    output Tx_Data, Write_En, CTS, Overflow_Clr,
    input  Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow, FIFO_Count
  );

  modport slave (
    input  Tx_Data, Write_En, CTS, Overflow_Clr,
    output Tx, Tx_Busy, FIFO_Empty, FIFO_Full, FIFO_Overflow, FIFO_Count
  );
endinterface

// File: rtl/uart_tx_engine.sv
// FIFO-buffered UART transmitter; a write into an idle empty engine puts the start bit on Tx two edges later.
// Writes while full are dropped and flagged sticky; CTS gates only the start of each frame.
module uart_tx_engine #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input logic             SysClk,
  input logic             Rst,
  uart_tx_engine_if.slave bus
);
  localparam int DIV   = SYSCLK_RATE / BAUD_RATE;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_engine: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     baud_cnt, baud_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_r, par_nxt;
  logic                 tx_r, tx_nxt;
  logic                 pop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 ovf;
  logic                 empty, full, push, ovf_set, start_ok, bit_end;
  logic [DATA_BITS-1:0] head;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign head     = mem[rd_ptr];
  assign start_ok = !empty && bus.CTS;
  assign bit_end  = (baud_cnt == CNT_W'(DIV - 1));
  // A pop on the same edge frees the slot, so a write to a full FIFO is still taken then.
  assign push     = bus.Write_En && (!full || pop);
  assign ovf_set  = bus.Write_En && full && !pop;

  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set)               ovf <= 1'b1;
      else if (bus.Overflow_Clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge SysClk) begin
    if (push) mem[wr_ptr] <= bus.Tx_Data;
  end

  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_r    <= 1'b0;
      tx_r     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      par_r    <= par_nxt;
      tx_r     <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end ? '0 : baud_cnt + CNT_W'(1);
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_r;
    tx_nxt    = tx_r;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (start_ok) begin
          pop       = 1'b1;
          shreg_nxt = head;
          par_nxt   = (^head) ^ (PARITY_MODE == 2);
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_nxt = '0;
            if (PARITY_MODE != 0) begin
              state_nxt = PARITY;
              tx_nxt    = par_r;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_nxt = '0;
            // Chain straight into the next frame when more data is waiting.
            if (start_ok) begin
              pop       = 1'b1;
              shreg_nxt = head;
              par_nxt   = (^head) ^ (PARITY_MODE == 2);
              state_nxt = START;
              tx_nxt    = 1'b0;
            end else begin
              state_nxt = IDLE;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

  assign bus.Tx            = tx_r;
  assign bus.Tx_Busy       = (state != IDLE);
  assign bus.FIFO_Empty    = empty;
  assign bus.FIFO_Full     = full;
  assign bus.FIFO_Overflow = ovf;
  assign bus.FIFO_Count    = count;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: serial frames decoded and scored against a queue of accepted words.
module tb_uart_tx_engine;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_engine_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) a_if ();
  uart_tx_engine_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b_if ();

  uart_tx_engine #(
    .SYSCLK_RATE(1600), .BAUD_RATE(100), .DATA_BITS(8),
    .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_a (.SysClk(clk), .Rst(rst_n), .bus(a_if));

  uart_tx_engine #(
    .SYSCLK_RATE(1600), .BAUD_RATE(100), .DATA_BITS(8),
    .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_b (.SysClk(clk), .Rst(rst_n), .bus(b_if));

  int checks = 0;
  int errors = 0;
  logic mon_en;
  logic [7:0] exp_q [$];

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       clr;
    logic       acc;
    int         cnt;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame decoder for dut_a: samples the middle of each bit after a falling start edge.
  initial begin
    logic [11:0] f;
    logic [7:0]  w;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && a_if.Tx === 1'b0) begin
        repeat (DIV / 2) @(posedge clk);
        #2;
        f[0] = a_if.Tx;
        for (int b = 1; b < 12; b++) begin
          repeat (DIV) @(posedge clk);
          #2;
          f[b] = a_if.Tx;
        end
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got frame %0h, expected no frame", f);
          end else begin
            w = exp_q.pop_front();
            check("frame", 32'(f), 32'({2'b11, ^w, w, 1'b0}));
          end
        end
      end
    end
  end

  initial begin
    logic [11:0] fa;
    logic [10:0] fb;
    int mism, busy;
    logic par_s;
    logic [7:0] words [3];

    vecs[0] = '{we: 1'b1, d: 8'h11, clr: 1'b0, acc: 1'b1, cnt: 1, full: 1'b0, ovf: 1'b0};
    vecs[1] = '{we: 1'b1, d: 8'h22, clr: 1'b0, acc: 1'b1, cnt: 2, full: 1'b0, ovf: 1'b0};
    vecs[2] = '{we: 1'b1, d: 8'h33, clr: 1'b0, acc: 1'b1, cnt: 3, full: 1'b0, ovf: 1'b0};
    vecs[3] = '{we: 1'b1, d: 8'h44, clr: 1'b0, acc: 1'b1, cnt: 4, full: 1'b1, ovf: 1'b0};
    vecs[4] = '{we: 1'b1, d: 8'h55, clr: 1'b0, acc: 1'b0, cnt: 4, full: 1'b1, ovf: 1'b1};
    vecs[5] = '{we: 1'b0, d: 8'h00, clr: 1'b1, acc: 1'b0, cnt: 4, full: 1'b1, ovf: 1'b0};
    vecs[6] = '{we: 1'b1, d: 8'h56, clr: 1'b1, acc: 1'b0, cnt: 4, full: 1'b1, ovf: 1'b1};
    vecs[7] = '{we: 1'b0, d: 8'h00, clr: 1'b1, acc: 1'b0, cnt: 4, full: 1'b1, ovf: 1'b0};
    vecs[8] = '{we: 1'b0, d: 8'h00, clr: 1'b0, acc: 1'b0, cnt: 4, full: 1'b1, ovf: 1'b0};

    fa = 12'b1101_0100_1010;   // 0xA5, even parity, two stops; bit 0 is the start bit
    fb = 11'b110_0000_0000;    // 0x00, odd parity, one stop
    words[0] = 8'h77; words[1] = 8'h88; words[2] = 8'h99;

    rst_n = 1'b0;
    mon_en = 1'b1;
    a_if.Tx_Data = '0; a_if.Write_En = 1'b0; a_if.CTS = 1'b0; a_if.Overflow_Clr = 1'b0;
    b_if.Tx_Data = '0; b_if.Write_En = 1'b0; b_if.CTS = 1'b0; b_if.Overflow_Clr = 1'b0;
    repeat (3) step();
    check("rst_tx", 32'(a_if.Tx), 32'd1);
    check("rst_busy", 32'(a_if.Tx_Busy), 32'd0);
    check("rst_count", 32'(a_if.FIFO_Count), 32'd0);
    check("rst_empty", 32'(a_if.FIFO_Empty), 32'd1);
    check("rst_full", 32'(a_if.FIFO_Full), 32'd0);
    check("rst_ovf", 32'(a_if.FIFO_Overflow), 32'd0);
    rst_n = 1'b1;
    step();

    // Single frame 0xA5: two-edge latency, then exact per-clock waveform.
    a_if.CTS = 1'b1; a_if.Tx_Data = 8'hA5; a_if.Write_En = 1'b1;
    exp_q.push_back(8'hA5);
    step();
    a_if.Write_En = 1'b0;
    check("lat_count", 32'(a_if.FIFO_Count), 32'd1);
    check("lat_tx_hold", 32'(a_if.Tx), 32'd1);
    step();
    check("lat_tx_start", 32'(a_if.Tx), 32'd0);
    mism = 0; busy = 0;
    for (int k = 0; k < 200; k++) begin
      if (a_if.Tx !== ((k < 192) ? fa[k / DIV] : 1'b1)) mism++;
      if (a_if.Tx_Busy) busy++;
      step();
    end
    check("a5_wave_mismatches", 32'(mism), 32'd0);
    check("a5_busy_clocks", 32'(busy), 32'd192);

    // Fill, overflow and clear with CTS held low.
    a_if.CTS = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a_if.Write_En = vecs[i].we;
      a_if.Tx_Data = vecs[i].d;
      a_if.Overflow_Clr = vecs[i].clr;
      if (vecs[i].we && vecs[i].acc) exp_q.push_back(vecs[i].d);
      step();
      check($sformatf("v%0d_count", i), 32'(a_if.FIFO_Count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_full", i), 32'(a_if.FIFO_Full), 32'(vecs[i].full));
      check($sformatf("v%0d_empty", i), 32'(a_if.FIFO_Empty), 32'(vecs[i].cnt == 0));
      check($sformatf("v%0d_ovf", i), 32'(a_if.FIFO_Overflow), 32'(vecs[i].ovf));
      check($sformatf("v%0d_tx", i), 32'(a_if.Tx), 32'd1);
    end
    a_if.Write_En = 1'b0; a_if.Overflow_Clr = 1'b0;

    // Write on the pop edge of a full FIFO, then five frames back to back.
    a_if.CTS = 1'b1; a_if.Tx_Data = 8'h66; a_if.Write_En = 1'b1;
    exp_q.push_back(8'h66);
    step();
    a_if.Write_En = 1'b0;
    check("popwr_count", 32'(a_if.FIFO_Count), 32'd4);
    check("popwr_full", 32'(a_if.FIFO_Full), 32'd1);
    check("popwr_ovf", 32'(a_if.FIFO_Overflow), 32'd0);
    check("popwr_tx", 32'(a_if.Tx), 32'd0);
    busy = 0;
    for (int k = 0; k < 960; k++) begin
      if (a_if.Tx_Busy) busy++;
      step();
    end
    check("b2b5_busy_clocks", 32'(busy), 32'd960);
    check("b2b5_busy_end", 32'(a_if.Tx_Busy), 32'd0);
    check("b2b5_empty", 32'(a_if.FIFO_Empty), 32'd1);
    check("b2b5_tx_idle", 32'(a_if.Tx), 32'd1);

    // Three queued words; CTS dropped in the middle of frame two.
    a_if.CTS = 1'b0;
    a_if.Write_En = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.Tx_Data = words[i];
      exp_q.push_back(words[i]);
      step();
    end
    a_if.Write_En = 1'b0;
    check("q3_count", 32'(a_if.FIFO_Count), 32'd3);
    check("q3_tx_hold", 32'(a_if.Tx), 32'd1);
    a_if.CTS = 1'b1;
    step();
    check("q3_tx_start", 32'(a_if.Tx), 32'd0);
    check("q3_count_pop", 32'(a_if.FIFO_Count), 32'd2);
    busy = 0;
    for (int k = 0; k < 384; k++) begin
      if (k == 288) a_if.CTS = 1'b0;
      if (a_if.Tx_Busy) busy++;
      step();
    end
    check("cts_drop_busy_clocks", 32'(busy), 32'd384);
    mism = 0; busy = 0;
    for (int k = 0; k < 64; k++) begin
      if (a_if.Tx !== 1'b1) mism++;
      if (a_if.Tx_Busy) busy++;
      step();
    end
    check("cts_drop_tx_low_clocks", 32'(mism), 32'd0);
    check("cts_drop_busy_after", 32'(busy), 32'd0);
    check("cts_drop_count", 32'(a_if.FIFO_Count), 32'd1);
    check("cts_drop_pending", 32'(exp_q.size()), 32'd1);

    // Asynchronous reset in the middle of the data bits with one word still queued.
    a_if.CTS = 1'b1; a_if.Tx_Data = 8'hC3; a_if.Write_En = 1'b1;
    step();
    a_if.Write_En = 1'b0;
    check("rstmid_count_pre", 32'(a_if.FIFO_Count), 32'd1);
    repeat (56) step();
    check("rstmid_busy_pre", 32'(a_if.Tx_Busy), 32'd1);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", 32'(a_if.Tx), 32'd1);
    check("rstmid_count", 32'(a_if.FIFO_Count), 32'd0);
    check("rstmid_busy", 32'(a_if.Tx_Busy), 32'd0);
    check("rstmid_empty", 32'(a_if.FIFO_Empty), 32'd1);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    mism = 0; busy = 0;
    for (int k = 0; k < 300; k++) begin
      if (a_if.Tx !== 1'b1) mism++;
      if (a_if.Tx_Busy) busy++;
      step();
    end
    check("post_rst_tx_low_clocks", 32'(mism), 32'd0);
    check("post_rst_busy_clocks", 32'(busy), 32'd0);
    check("post_rst_count", 32'(a_if.FIFO_Count), 32'd0);

    // Odd parity, one stop bit.
    b_if.CTS = 1'b1; b_if.Tx_Data = 8'h00; b_if.Write_En = 1'b1;
    step();
    b_if.Write_En = 1'b0;
    check("odd_count", 32'(b_if.FIFO_Count), 32'd1);
    step();
    check("odd_tx_start", 32'(b_if.Tx), 32'd0);
    mism = 0; busy = 0; par_s = 1'b0;
    for (int k = 0; k < 184; k++) begin
      if (b_if.Tx !== ((k < 176) ? fb[k / DIV] : 1'b1)) mism++;
      if (b_if.Tx_Busy) busy++;
      if (k == 9 * DIV + DIV / 2) par_s = b_if.Tx;
      step();
    end
    check("odd_wave_mismatches", 32'(mism), 32'd0);
    check("odd_busy_clocks", 32'(busy), 32'd176);
    check("odd_parity_bit", 32'(par_s), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
